// File: rtl/mips_isa_pkg.sv
// Shared MIPS encodings used by the instruction encoder and the control decoder.
package mips_isa_pkg;

    // Primary opcodes (instr[31:26]).
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_JAL     = 6'h03;

    // SPECIAL function codes (instr[5:0]).
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_JR   = 6'h08;

    // Symbolic instruction select; codes 9-15 are invalid.
    typedef enum logic [3:0] {
        INSN_ADDU = 4'd0,
        INSN_SUBU = 4'd1,
        INSN_ORI  = 4'd2,
        INSN_LW   = 4'd3,
        INSN_SW   = 4'd4,
        INSN_BEQ  = 4'd5,
        INSN_LUI  = 4'd6,
        INSN_JAL  = 4'd7,
        INSN_JR   = 4'd8
    } insn_e;

endpackage

// File: rtl/mips_instr_fifo.sv
// DEPTH x 32 synchronous FIFO with full/empty flags and a synchronous flush.
module mips_instr_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] head,
    output logic        full,
    output logic        empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; flush wins over push and pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (!flush && push && !full) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instructions and streams them into instruction memory.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [25:0] in_imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic        err_invalid,
    output logic [15:0] words_written
);

    // Returns {valid, word}; unused fields never reach the word.
    function automatic logic [32:0] encode(input logic [3:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [25:0] imm);
        logic [32:0] r;
        r = '0;
        case (insn_e'(op))
            INSN_ADDU: r = {1'b1, OP_SPECIAL, rs, rt, rd, 5'h00, FN_ADDU};
            INSN_SUBU: r = {1'b1, OP_SPECIAL, rs, rt, rd, 5'h00, FN_SUBU};
            INSN_ORI:  r = {1'b1, OP_ORI, rs, rt, imm[15:0]};
            INSN_LW:   r = {1'b1, OP_LW, rs, rt, imm[15:0]};
            INSN_SW:   r = {1'b1, OP_SW, rs, rt, imm[15:0]};
            INSN_BEQ:  r = {1'b1, OP_BEQ, rs, rt, imm[15:0]};
            INSN_LUI:  r = {1'b1, OP_LUI, 5'h00, rt, imm[15:0]};
            INSN_JAL:  r = {1'b1, OP_JAL, imm};
            INSN_JR:   r = {1'b1, OP_SPECIAL, rs, 15'h0000, FN_JR};
            default:   r = '0;
        endcase
        return r;
    endfunction

    logic [32:0] enc;
    logic        enc_valid;
    logic        accept;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

    logic [31:0] addr_q;
    logic [15:0] count_q;
    logic        err_q;

    assign enc       = encode(in_op, in_rs, in_rt, in_rd, in_imm);
    assign enc_valid = enc[32];

    // No same-cycle bypass: a full FIFO refuses even while it is popping.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready && !clear;
    assign push     = accept && enc_valid;
    assign pop      = mem_we && mem_ack && !clear;

    assign mem_we        = !fifo_empty;
    assign mem_wdata     = fifo_empty ? 32'h0 : fifo_head;
    assign mem_addr      = addr_q;
    assign err_invalid   = err_q;
    assign words_written = count_q;

    mips_instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (clear),
        .push     (push),
        .push_data(enc[31:0]),
        .pop      (pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Write address, completed-write counter and sticky invalid-op flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (clear) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop) begin
                addr_q  <= addr_q + 32'd4;
                count_q <= count_q + 16'd1;
            end
            if (accept && !enc_valid) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomised and directed bench for mips_instr_encoder with a queue-based model.
module tb_mips_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [25:0] in_imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        err_invalid;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;

    mips_instr_encoder #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_imm       (in_imm),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .err_invalid  (err_invalid),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding written as field arithmetic; bit 32 = valid.
    function automatic logic [32:0] ref_encode(input int op, input int rs, input int rt,
                                               input int rd, input int imm);
        longint w;
        longint i16;
        i16 = imm & 32'hFFFF;
        case (op)
            0: w = rs * 2097152 + rt * 65536 + rd * 2048 + 33;
            1: w = rs * 2097152 + rt * 65536 + rd * 2048 + 35;
            2: w = 13 * 67108864 + rs * 2097152 + rt * 65536 + i16;
            3: w = 35 * 67108864 + rs * 2097152 + rt * 65536 + i16;
            4: w = 43 * 67108864 + rs * 2097152 + rt * 65536 + i16;
            5: w = 4 * 67108864 + rs * 2097152 + rt * 65536 + i16;
            6: w = 15 * 67108864 + rt * 65536 + i16;
            7: w = 3 * 67108864 + (imm & 32'h03FF_FFFF);
            8: w = rs * 2097152 + 8;
            default: return 33'h0;
        endcase
        return {1'b1, w[31:0]};
    endfunction

    // Model state.
    logic [31:0] mq[$];
    logic [31:0] m_addr = BASE;
    int          m_count = 0;
    logic        m_err = 1'b0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_addr  = BASE;
            m_count = 0;
            m_err   = 1'b0;
        end else if (clear) begin
            mq.delete();
            m_addr  = BASE;
            m_count = 0;
            m_err   = 1'b0;
        end else begin
            logic        acc;
            logic        popv;
            logic [32:0] e;
            acc  = in_valid && (mq.size() < DEPTH);
            popv = (mq.size() > 0) && mem_ack;
            e    = ref_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_imm));
            if (popv) begin
                log_addr.push_back(m_addr);
                log_data.push_back(mq[0]);
                void'(mq.pop_front());
                m_addr  = m_addr + 32'd4;
                m_count = (m_count + 1) % 65536;
            end
            if (acc && e[32]) mq.push_back(e[31:0]);
            if (acc && !e[32]) m_err = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            check("mem_we", {31'b0, mem_we}, {31'b0, mq.size() != 0});
            check("in_ready", {31'b0, in_ready}, {31'b0, mq.size() < DEPTH});
            check("mem_addr", mem_addr, m_addr);
            if (mq.size() != 0) check("mem_wdata", mem_wdata, mq[0]);
            check("err_invalid", {31'b0, err_invalid}, {31'b0, m_err});
            check("words_written", {16'b0, words_written}, m_count[31:0]);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
        int n = 0;
        in_valid = 1'b1;
        in_op  = op[3:0];
        in_rs  = rs[4:0];
        in_rt  = rt[4:0];
        in_rd  = rd[4:0];
        in_imm = imm[25:0];
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low, op %0d", op);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mem_we || mq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_we || mq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: mem_we %0b model size %0d", mem_we, mq.size());
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic check_log(input int idx, input logic [31:0] a, input logic [31:0] d);
        checks++;
        if (idx >= log_addr.size()) begin
            errors++;
            $display("FAIL log_missing: entry %0d absent, size %0d", idx, log_addr.size());
        end else begin
            check("log_addr", log_addr[idx], a);
            check("log_data", log_data[idx], d);
        end
    endtask

    initial begin
        logic [31:0] held_data;
        repeat (2) @(negedge clk);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_3000);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_err", {31'b0, err_invalid}, 32'd0);
        check("rst_words", {16'b0, words_written}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Single ops at successive addresses.
        mem_ack = 1'b1;
        send(0, 1, 2, 3, 0);
        send(2, 0, 1, 0, 32'h1234);
        send(3, 1, 2, 0, 4);
        send(7, 0, 0, 0, 32'h0000C00);
        send(8, 31, 0, 0, 0);
        wait_idle();
        check_log(0, 32'h3000, 32'h00221821);
        check_log(1, 32'h3004, 32'h34011234);
        check_log(2, 32'h3008, 32'h8C220004);
        check_log(3, 32'h300C, 32'h0C000C00);
        check_log(4, 32'h3010, 32'h03E00008);

        // Field masking.
        pulse_clear();
        send(6, 7, 5, 0, 32'h2ABCD);
        send(8, 31, 31, 31, 32'h3FFFFFF);
        wait_idle();
        check_log(0, 32'h3000, 32'h3C05ABCD);
        check_log(1, 32'h3004, 32'h03E00008);

        // Back-pressure.
        pulse_clear();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) send(4, 2, 3, 0, i * 4);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        held_data = mem_wdata;
        check("bp_hold_data0", held_data, 32'hAC430000);
        repeat (3) @(negedge clk);
        check("bp_hold_we", {31'b0, mem_we}, 32'd1);
        check("bp_hold_addr", mem_addr, 32'h3000);
        check("bp_hold_data", mem_wdata, held_data);
        mem_ack = 1'b1;
        wait_idle();
        for (int i = 0; i < 4; i++) check_log(i, 32'h3000 + i * 4, 32'hAC430000 + i * 4);
        check("bp_words", {16'b0, words_written}, 32'd4);
        check("bp_ready_back", {31'b0, in_ready}, 32'd1);

        // Invalid op then a valid subu.
        pulse_clear();
        send(15, 1, 2, 3, 0);
        check("inv_err", {31'b0, err_invalid}, 32'd1);
        check("inv_we", {31'b0, mem_we}, 32'd0);
        check("inv_addr", mem_addr, 32'h3000);
        send(1, 4, 5, 6, 0);
        wait_idle();
        check_log(0, 32'h3000, 32'h00853023);
        check("inv_err_sticky", {31'b0, err_invalid}, 32'd1);

        // Clear mid-stream with a request presented in the clear cycle.
        mem_ack = 1'b0;
        send(0, 1, 1, 1, 0);
        send(0, 2, 2, 2, 0);
        send(0, 3, 3, 3, 0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_op = 4'd0;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check("clr_we", {31'b0, mem_we}, 32'd0);
        check("clr_addr", mem_addr, 32'h3000);
        check("clr_words", {16'b0, words_written}, 32'd0);
        check("clr_err", {31'b0, err_invalid}, 32'd0);
        @(negedge clk);
        check("clr_not_stored", {31'b0, mem_we}, 32'd0);

        // Reset mid-write.
        log_addr.delete();
        log_data.delete();
        send(2, 1, 1, 0, 32'h55);
        #3 reset = 1'b0;
        #1;
        check("mrst_we", {31'b0, mem_we}, 32'd0);
        check("mrst_addr", mem_addr, 32'h3000);
        check("mrst_wdata", mem_wdata, 32'd0);
        check("mrst_words", {16'b0, words_written}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1;
        send(5, 1, 2, 0, 32'hFFFF);
        wait_idle();
        check_log(0, 32'h3000, 32'h1022FFFF);

        // Randomised traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op    = ($urandom_range(0, 15) < 14) ? 4'($urandom_range(0, 8))
                                                    : 4'($urandom_range(9, 15));
            in_rs    = 5'($urandom);
            in_rt    = 5'($urandom);
            in_rd    = 5'($urandom);
            in_imm   = 26'($urandom);
            mem_ack  = ($urandom_range(0, 2) != 0);
            clear    = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        clear = 1'b0;
        mem_ack = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
